// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: Diff = A - B - Bin, one bit per clock.
// A single full-subtractor cell feeds a result shift register; outputs update only on completion.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic a_i, b_i, d_i, br_next, last;

  always_comb begin
    a_i     = a_q[cnt_q];
    b_i     = b_q[cnt_q];
    d_i     = a_i ^ b_i ^ br_q;
    br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
    last    = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // LSB-first: each new bit enters at the top and walks down.
        res_d = {d_i, res_q[WIDTH-1:1]};
        br_d  = br_next;
        if (last) begin
          diff_d  = res_d;
          bout_d  = br_next;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4).
// Directed vector table, handshake corner cases and a random sweep vs. an arithmetic model.
module tb_serial_ripple_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic         busy, done;
  logic [W-1:0] Diff;
  logic         Bout;

  int checks = 0;
  int errors = 0;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, modulo 2^W, borrow when A < B + Bin.
  task automatic model(input int a, input int b, input int bin,
                       output int d, output int bo);
    d  = (a - b - bin) & ((1 << W) - 1);
    bo = (a < b + bin) ? 1 : 0;
  endtask

  // Called at a negedge with the DUT idle; leaves it idle at a negedge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input int exp_d, input int exp_bo,
                       input string tag);
    int lat;
    int bcnt;
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
    chk({tag, " latency"}, lat, W);
    chk({tag, " busy_cycles"}, bcnt, W + 1);
    chk({tag, " diff"}, int'(Diff), exp_d);
    chk({tag, " bout"}, int'(Bout), exp_bo);
    @(negedge clk);
    chk({tag, " idle_busy"}, int'(busy), 0);
    chk({tag, " idle_done"}, int'(done), 0);
    chk({tag, " hold_diff"}, int'(Diff), exp_d);
  endtask

  initial begin
    vec_t vecs[6];
    int   d, bo, ndone;
    logic [W-1:0] ra, rb;
    logic rbin;

    vecs[0] = '{a: 4'b0101, b: 4'b0001, bin: 1'b0, d: 4'b0100, bo: 1'b0};
    vecs[1] = '{a: 4'b0010, b: 4'b0001, bin: 1'b1, d: 4'b0000, bo: 1'b0};
    vecs[2] = '{a: 4'b0000, b: 4'b0001, bin: 1'b1, d: 4'b1110, bo: 1'b1};
    vecs[3] = '{a: 4'b0001, b: 4'b1111, bin: 1'b1, d: 4'b0001, bo: 1'b1};
    vecs[4] = '{a: 4'b1111, b: 4'b1111, bin: 1'b0, d: 4'b0000, bo: 1'b0};
    vecs[5] = '{a: 4'b0000, b: 4'b0000, bin: 1'b1, d: 4'b1111, bo: 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst diff", int'(Diff), 0);
    chk("rst bout", int'(Bout), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin,
            int'(vecs[i].d), int'(vecs[i].bo), $sformatf("vec%0d", i));

    // Input changes and a second start during RUN must be ignored.
    A = 4'b0101; B = 4'b0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 4'b1111; B = 4'b0011; Bin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ignore ndone", ndone, 1);
    chk("ignore diff", int'(Diff), 4);
    chk("ignore bout", int'(Bout), 0);

    // Reset at the second RUN cycle aborts the operation.
    A = 4'b0101; B = 4'b0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort ndone", ndone, 0);
    chk("abort diff", int'(Diff), 0);
    chk("abort bout", int'(Bout), 0);
    chk("abort busy", int'(busy), 0);
    do_op(4'b1001, 4'b0011, 1'b1, 5, 0, "post_abort");

    // Random back-to-back sweep.
    for (int i = 0; i < 300; i++) begin
      ra   = W'($urandom_range(0, (1 << W) - 1));
      rb   = W'($urandom_range(0, (1 << W) - 1));
      rbin = 1'($urandom_range(0, 1));
      model(int'(ra), int'(rb), int'(rbin), d, bo);
      do_op(ra, rb, rbin, d, bo, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial ripple-borrow subtractor. It is the inverse operation of the team's 4-bit ripple-carry adder.
- Computes Diff = A - B - Bin over WIDTH bits, one bit per clock, using a single full-subtractor cell and a registered borrow.
- Uses a start/busy/done handshake. Sits beside the adder in the arithmetic datapath, where area matters more than latency.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on start acceptance.
- B  input  WIDTH  subtrahend; captured on start acceptance.
- Bin  input  1  borrow-in; captured on start acceptance.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; Diff/Bout valid and final.
- Diff  output  WIDTH  result, registered.
- Bout  output  1  borrow-out, registered.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - busy=0, done=0, Diff=0, Bout=0.
  - Internal operand registers, bit counter and borrow register all clear to 0.
  - Reset has priority over every other event.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - If start=1 at an edge: capture A, B and Bin into internal registers (borrow reg <= Bin), set counter=0, go to RUN.
  - Otherwise stay in IDLE. Inputs are don't-care.
- RUN: each edge processes bit i=counter.
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i is shifted into the internal result shift register; br <= br_next; counter increments.
  - At the edge processing bit WIDTH-1: Diff <= full internal result, Bout <= br_next, go to DONE.
- DONE: done=1 for exactly this one cycle. The next edge goes to IDLE.
- Latency: start is accepted at edge E. done is high in the cycle after edge E+WIDTH, i.e. WIDTH clocks after acceptance. Throughput is one operation per WIDTH+2 clocks.
- Output hold and handshake:
  - Diff and Bout change only on entry to DONE or on reset. No partial results are ever visible.
  - They hold their values until the next operation completes.
  - start while busy=1 (RUN or DONE) is ignored and is not queued.
  - A, B and Bin changing during RUN have no effect.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Bout=1 exactly when A < B + Bin, evaluated as unsigned integers.
  - Diff equals (A - B - Bin) mod 2^WIDTH.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and Diff/Bout are forced to 0.
- Boundary cases:
  - A=B, Bin=0: Diff=0, Bout=0.
  - A=0, B=0, Bin=1: Diff = all ones, Bout=1.
  - Counter must not wrap past WIDTH-1 in RUN.
- done and busy are registered or state-decoded only; no combinational path from inputs to any output.

Test Plan:
- Reset, then A=0101, B=0001, Bin=0, start pulse -> done exactly 4 clocks after accept; Diff=0100, Bout=0; busy high for 5 cycles.
- A=0010, B=0001, Bin=1 -> Diff=0000, Bout=0. Then A=0000, B=0001, Bin=1 -> Diff=1110, Bout=1.
- A=0001, B=1111, Bin=1 -> Diff=0001, Bout=1. Then A=1111, B=1111, Bin=0 -> Diff=0000, Bout=0.
- Start with A=0101, B=0001, then during RUN change A/B and re-assert start -> one done only, Diff=0100; the second start is ignored.
- Start an operation and assert rst at the 2nd RUN cycle -> no done; Diff=0, Bout=0, busy=0. A fresh start afterwards completes normally.
- Randomised sweep over all 4-bit A, B, Bin with a back-to-back start on every IDLE cycle -> every result matches the reference model (A-B-Bin) mod 16, and every Bout matches the borrow condition.
